// File: rtl/reg_block_mover.sv
// Block mover between a 32-entry register file and a pair of valid/ready streams.
// STORE streams registers out through a registered output stage; LOAD writes stream beats into registers.
module reg_block_mover #(
    parameter int WIDTH   = 64,
    parameter bit SKIP_R0 = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dir,
    input  logic [4:0]       first_reg,
    input  logic [5:0]       count,
    output logic             busy,
    output logic             done,
    output logic [4:0]       rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [4:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             reg_write,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_STORE | reading registers into the output stream
    // S_LOAD  | writing input stream beats into registers
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_rd_idx;
    logic [4:0]       r_wr_idx;
    logic [5:0]       r_count;
    logic [5:0]       r_nread;
    logic [5:0]       r_nxfer;
    logic             r_prime;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [5:0]       w_eff_count;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_fetch;
    logic             w_last_xfer;
    logic             w_beat;
    logic             w_last_beat;

    assign w_eff_count = (count > 6'd32) ? 6'd32 : count;
    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_xfer      = (r_state == S_STORE) && r_out_valid && out_ready;
    // r_prime holds off the first fetch one cycle so rd_addr settles on the new first register
    assign w_fetch     = (r_state == S_STORE) && !r_prime && (!r_out_valid || out_ready)
                         && (r_nread < r_count);
    assign w_last_xfer = w_xfer && (r_nxfer == r_count - 6'd1);
    assign w_beat      = (r_state == S_LOAD) && in_valid;
    assign w_last_beat = w_beat && (r_nxfer == r_count - 6'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_eff_count == 6'd0) w_next = S_DONE;
                    else if (dir)            w_next = S_LOAD;
                    else                     w_next = S_STORE;
                end
            end
            S_STORE: if (w_last_xfer) w_next = S_DONE;
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_last_beat) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_count     <= '0;
            r_nread     <= '0;
            r_nxfer     <= '0;
            r_prime     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_start_ok) begin
                r_rd_idx <= first_reg;
                r_wr_idx <= first_reg;
                r_count  <= w_eff_count;
                r_nread  <= '0;
                r_nxfer  <= '0;
                r_prime  <= 1'b1;
            end
            if (r_state == S_STORE) r_prime <= 1'b0;
            if (w_fetch) begin
                r_out_data <= rd_data;
                r_rd_idx   <= r_rd_idx + 5'd1;
                r_nread    <= r_nread + 6'd1;
            end
            if (w_xfer || w_beat) r_nxfer <= r_nxfer + 6'd1;
            if (w_beat) r_wr_idx <= r_wr_idx + 5'd1;
            if (w_fetch)     r_out_valid <= 1'b1;
            else if (w_xfer) r_out_valid <= 1'b0;
        end
    end

    assign rd_addr   = r_rd_idx;
    assign wr_addr   = r_wr_idx;
    assign wr_data   = (r_state == S_LOAD) ? in_data : '0;
    assign reg_write = w_beat && reset_n && !(SKIP_R0 && (r_wr_idx == 5'd0));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
